lfsr2: RTL and testbench

11-bit maximal-length Fibonacci linear-feedback shift register (LFSR) that produces a pseudo-random sequence from a loadable seed. The seed is captured from `in` on the first clock edge after reset release. After that the register advances one step per rising clock edge. It is a standalone stimulus/pseudo-random source: a consumer samples `out` once per cycle.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_step.sv | 25 ++
 rtl/lfsr2.sv | 65 ++++++
 tb/tb_lfsr2.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
//   Shared constants and types for the lfsr2 pseudo-random source.
//   Bits are numbered [1:WIDTH]: bit 1 is the MSB, bit WIDTH is the LSB.
//   - LFSR_WIDTH   : default register width (11)
//   - lfsr_state_t : [1:11] state vector
//   - TAPS_11      : feedback mask for x^11 + x^9 + 1 (bits 9 and 11 set)
// ----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_WIDTH = 11;

  typedef logic [1:LFSR_WIDTH] lfsr_state_t;

  // Rightmost position is bit 11, third from the right is bit 9.
  localparam lfsr_state_t TAPS_11 = 11'b000_0000_0101;

endpackage : lfsr_pkg

// File: rtl/lfsr_step.sv
// ----------------------------------------------------------------------------
// lfsr_step
//   Purely combinational single step of a Fibonacci LFSR.
//   Ports:
//     state      [1:WIDTH] in  : current register contents
//     taps       [1:WIDTH] in  : feedback mask, 1 marks a tapped bit
//     next_state [1:WIDTH] out : state after one shift toward the LSB,
//                                with the XOR of tapped bits entering bit 1
// ----------------------------------------------------------------------------
module lfsr_step #(
  parameter int WIDTH = 11
) (
  input  logic [1:WIDTH] state,
  input  logic [1:WIDTH] taps,
  output logic [1:WIDTH] next_state
);

  logic fb;

  always_comb begin
    fb         = ^(state & taps);
    next_state = {fb, state[1:WIDTH-1]};
  end

endmodule : lfsr_step

// File: rtl/lfsr2.sv
// ----------------------------------------------------------------------------
// lfsr2
//   Maximal-length Fibonacci LFSR with a loadable seed. The seed is taken
//   from `in` on the first rising edge after reset release (0 is replaced
//   by 1 so the register can never lock up); afterwards the register
//   advances one step per edge and `in` is ignored until the next reset.
//   Ports:
//     clk   in            : clock, rising edge active
//     rst_n in            : asynchronous active-low reset (out <= 0)
//     in    in  [1:WIDTH] : seed value
//     out   out [1:WIDTH] : current LFSR state, registered
// ----------------------------------------------------------------------------
module lfsr2
  import lfsr_pkg::*;
#(
  parameter int             WIDTH = LFSR_WIDTH,
  parameter logic [1:WIDTH] TAPS  = TAPS_11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:WIDTH] in,
  output logic [1:WIDTH] out
);

  logic [1:WIDTH] out_q, out_d;
  logic           seeded_q, seeded_d;
  logic [1:WIDTH] step_next;

  lfsr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .state      (out_q),
    .taps       (TAPS),
    .next_state (step_next)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    out_d    = out_q;
    seeded_d = seeded_q;
    if (!seeded_q) begin
      seeded_d = 1'b1;
      // Zero-lockup guard: an all-zero seed would never leave zero.
      out_d    = (in == '0) ? WIDTH'(1) : in;
    end else begin
      out_d    = step_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      seeded_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      seeded_q <= seeded_d;
    end
  end

  assign out = out_q;

endmodule : lfsr2

// File: tb/tb_lfsr2.sv
// ----------------------------------------------------------------------------
// tb_lfsr2
//   Scoreboard bench for lfsr2. The stimulus process pushes the expected
//   value of `out` for each rising edge into exp_q; the monitor pops and
//   compares on the following falling edge. Expected values come from the
//   listed reference sequence or from an integer model of the stepping rule.
// ----------------------------------------------------------------------------
module tb_lfsr2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:11] in_s = '0;
  logic [1:11] out_s;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int obs_log[$];
  bit log_en = 1'b0;

  // Reference sequence for seed 1.
  int seed1_seq[13] = '{1, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 1026, 513, 1280};

  lfsr2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_s),
    .out   (out_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Integer model: value LSB is bit 11, weight 4 is bit 9, weight 1024 is bit 1.
  function automatic int model_next(input int v);
    int fb;
    fb = (v & 1) ^ ((v >> 2) & 1);
    return (v >> 1) | (fb << 10);
  endfunction

  // Monitor: compare DUT output against scoreboard on each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      int e;
      e = exp_q.pop_front();
      check("seq", int'(out_s), e);
      if (log_en) obs_log.push_back(int'(out_s));
    end
  end

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #1;
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Hold reset, check cleared state, release mid-cycle with `in` = seed.
  task automatic do_reset(input int seed);
    rst_n = 1'b0;
    in_s  = 11'(seed);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", int'(out_s), 0);
    rst_n = 1'b1;
  endtask

  // Run n edges after release using the integer model.
  task automatic run_model(input int seed, input int n, input bit scramble_in);
    int v;
    v = (seed == 0) ? 1 : seed;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (k > 0) v = model_next(v);
      exp_q.push_back(v);
      #1;
      if (scramble_in) in_s = 11'($urandom_range(0, 2047));
    end
  endtask

  initial begin
    // Seed 1 against the reference table.
    do_reset(1);
    for (int k = 0; k < 13; k++) begin
      @(posedge clk);
      exp_q.push_back(seed1_seq[k]);
    end
    drain();

    // Zero seed: guard forces 1, then the seed-1 sequence.
    do_reset(0);
    for (int k = 0; k < 13; k++) begin
      @(posedge clk);
      exp_q.push_back(seed1_seq[k]);
    end
    drain();

    // Seed ignored after load: change `in` to 5 once seeded.
    do_reset(1);
    for (int k = 0; k < 13; k++) begin
      @(posedge clk);
      exp_q.push_back(seed1_seq[k]);
      #1;
      in_s = 11'd5;
    end
    drain();

    // Period: 2048 samples from seed 1, values 1..2047 once, 1 recurs.
    do_reset(1);
    obs_log.delete();
    log_en = 1'b1;
    run_model(1, 2048, 1'b0);
    drain();
    log_en = 1'b0;
    begin
      bit seen[2048];
      int dup, zero, missing;
      dup = 0; zero = 0; missing = 0;
      check("period_len", obs_log.size(), 2048);
      if (obs_log.size() == 2048) begin
        for (int i = 0; i < 2047; i++) begin
          if (obs_log[i] == 0) zero++;
          else if (obs_log[i] > 0 && obs_log[i] < 2048) begin
            if (seen[obs_log[i]]) dup++;
            seen[obs_log[i]] = 1'b1;
          end
        end
        for (int v = 1; v < 2048; v++) if (!seen[v]) missing++;
        check("period_dup", dup, 0);
        check("period_zero", zero, 0);
        check("period_missing", missing, 0);
        check("period_recur", obs_log[2047], 1);
      end
    end

    // Async reset mid-run, then reseed with 1234.
    do_reset(1);
    run_model(1, 20, 1'b0);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", int'(out_s), 0);
    in_s = 11'd1234;
    @(posedge clk);
    #1;
    check("reset_hold_out", int'(out_s), 0);
    rst_n = 1'b1;
    run_model(1234, 30, 1'b0);
    drain();

    // Steady state: random seed, 800 edges, `in` scrambled after seeding.
    begin
      int seed;
      seed = $urandom_range(0, 2047);
      do_reset(seed);
      run_model(seed, 800, 1'b1);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lfsr2
